// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_pkg
// Description : Shared state encoding, default widths and command priority
//               for the timer control stage.
// Revision    : 1.0 - initial release
// ============================================================================
package tmr_pkg;

    localparam int c_div_w_default = 8;

    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_run   = 2'b01;
    localparam logic [1:0] c_pause = 2'b10;
    localparam logic [1:0] c_done  = 2'b11;

    // Higher value wins when several commands arrive in the same cycle.
    localparam int c_prio_clear = 2;
    localparam int c_prio_stop  = 1;
    localparam int c_prio_start = 0;

    function automatic logic is_busy(input logic [1:0] st);
        return (st == c_run) || (st == c_pause);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tmr_prescaler
// Description : Counts 0..div_reg while run is high and emits a registered
//               one-cycle tick on each wrap; reload forces the count to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_prescaler
    import tmr_pkg::*;
#(
    parameter int DIV_W = c_div_w_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             reload,
    input  logic [DIV_W-1:0] div_reg,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (reload) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (run) begin
            if (r_cnt == div_reg) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/tmr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tmr_ctrl
// Description : Start/stop/pause/clear control for the 8-bit counter with
//               prescaled count_en, one-shot/periodic modes and sticky irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_ctrl
    import tmr_pkg::*;
#(
    parameter int DIV_W = c_div_w_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             one_shot,
    input  logic [DIV_W-1:0] div_val,
    input  logic             overflow,
    input  logic             irq_clr,
    output logic             count_en,
    output logic             count_clr,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [1:0]       state
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic             r_mode;
    logic             r_count_clr;
    logic             r_done;
    logic             r_irq;
    logic             w_tick;
    logic             w_run;
    logic             w_reload;
    logic             w_start_idle;
    logic             w_ovf;

    assign w_run        = (r_state == c_run);
    assign w_start_idle = (r_state == c_idle) && start && !clear;
    assign w_reload     = clear || w_start_idle;
    assign w_ovf        = w_run && count_en && overflow;

    // The prescaler keeps advancing in the cycle a stop is taken; the tick it
    // may produce on entering PAUSE or DONE is masked by the state below.
    tmr_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (w_run),
        .reload  (w_reload),
        .div_reg (r_div),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_idle;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) w_state_nxt = c_run;
                end
                c_run: begin
                    if (w_ovf && r_mode)  w_state_nxt = c_done;
                    else if (stop)        w_state_nxt = c_pause;
                end
                c_pause: begin
                    if (!stop && start)   w_state_nxt = c_run;
                end
                c_done: begin
                    w_state_nxt = c_idle;
                end
                default: begin
                    w_state_nxt = c_idle;
                end
            endcase
        end
    end

    always_comb begin
        count_en  = w_tick && w_run;
        count_clr = r_count_clr;
        busy      = is_busy(r_state);
        done      = r_done;
        irq       = r_irq;
        state     = r_state;
    end

    // Overflow sets irq even when a clear arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_mode      <= 1'b0;
            r_count_clr <= 1'b0;
            r_done      <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_count_clr <= w_reload;
            r_done      <= !clear && w_ovf && r_mode;
            if (w_start_idle) begin
                r_div  <= div_val;
                r_mode <= one_shot;
            end
            if (w_ovf) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
